// File: rtl/wb_master_arbiter.sv
// Wishbone classic master that arbitrates N word-addressed requesters onto one bus; cyc/stb rise one
// cycle after a request and ack/err pulse one cycle after the slave answers. Requesters hold i_req until then.
module wb_master_arbiter #(
    parameter int N_MASTERS  = 2,
    parameter int ADR_WIDTH  = 30,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int ARB_MODE   = 1,
    parameter int TIMEOUT    = 255,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                            i_clk,
    input  logic                            i_arst_n,
    input  logic [N_MASTERS-1:0]            i_req,
    input  logic [N_MASTERS-1:0]            i_wr,
    input  logic [N_MASTERS*SEL_WIDTH-1:0]  i_sel,
    input  logic [N_MASTERS*ADR_WIDTH-1:0]  i_adr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] i_dat,
    output logic [DATA_WIDTH-1:0]           o_dat,
    output logic [N_MASTERS-1:0]            o_ack,
    output logic [N_MASTERS-1:0]            o_err,
    output logic [N_MASTERS-1:0]            o_grant,
    output logic                            o_busy,
    output logic                            o_wb_cyc,
    output logic                            o_wb_stb,
    output logic                            o_wb_we,
    output logic [SEL_WIDTH-1:0]            o_wb_sel,
    output logic [ADR_WIDTH+1:0]            o_wb_adr,
    output logic [DATA_WIDTH-1:0]           o_wb_dat,
    input  logic [DATA_WIDTH-1:0]           i_wb_dat,
    input  logic                            i_wb_ack,
    input  logic                            i_wb_err
);
    localparam int PTR_W = $clog2(N_MASTERS);
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t                 state_q;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [CNT_WIDTH-1:0]   wd_cnt_q;

    logic [PTR_W-1:0]       rot_amt;
    logic [2*N_MASTERS-1:0] req_dbl;
    logic [N_MASTERS-1:0]   req_rot;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       ptr_d;
    logic                   req_any;
    logic                   bus_end;
    int                     win_sum;

    // Rotating the request vector by the pointer turns round robin into a lowest-index search.
    assign rot_amt = (ARB_MODE == 0) ? '0 : rr_ptr_q;
    assign req_dbl = {i_req, i_req};
    assign req_rot = N_MASTERS'(req_dbl >> rot_amt);
    assign req_any = |i_req;
    assign bus_end = i_wb_err || i_wb_ack || ((TIMEOUT != 0) && (wd_cnt_q == TO_LAST));

    always_comb begin
        win_sum = 0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (req_rot[i]) win_sum = i;
        end
        win_sum = win_sum + int'(rot_amt);
        if (win_sum >= N_MASTERS) win_sum = win_sum - N_MASTERS;
        win_idx = PTR_W'(win_sum);
        ptr_d   = (win_idx == PTR_W'(N_MASTERS - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            wd_cnt_q <= '0;
            o_dat    <= '0;
            o_ack    <= '0;
            o_err    <= '0;
            o_grant  <= '0;
            o_busy   <= 1'b0;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            o_wb_sel <= '0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wd_cnt_q <= '0;
                    if (req_any) begin
                        o_grant  <= N_MASTERS'(1) << win_idx;
                        o_busy   <= 1'b1;
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        o_wb_we  <= i_wr[win_idx];
                        o_wb_sel <= i_sel[win_sum*SEL_WIDTH +: SEL_WIDTH];
                        o_wb_adr <= {i_adr[win_sum*ADR_WIDTH +: ADR_WIDTH], 2'b00};
                        o_wb_dat <= i_dat[win_sum*DATA_WIDTH +: DATA_WIDTH];
                        rr_ptr_q <= ptr_d;
                        state_q  <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (bus_end) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        state_q  <= S_DONE;
                        // Error beats a simultaneous ack; either beats the watchdog.
                        if (i_wb_ack && !i_wb_err) begin
                            o_ack <= o_grant;
                            o_dat <= o_wb_we ? '0 : i_wb_dat;
                        end else begin
                            o_err <= o_grant;
                            o_dat <= '0;
                        end
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CNT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    o_ack    <= '0;
                    o_err    <= '0;
                    o_dat    <= '0;
                    o_grant  <= '0;
                    o_busy   <= 1'b0;
                    o_wb_we  <= 1'b0;
                    o_wb_sel <= '0;
                    o_wb_adr <= '0;
                    o_wb_dat <= '0;
                    wd_cnt_q <= '0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
